// File: rtl/dct_pkg.sv
// Shared constants for the zigzag/quantize stage: scan tables, block geometry
// and the read-side FSM encoding.
package dct_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int ADDR_W     = 6;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PRIME  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  // Zigzag index k -> raster address (row*8+col).
  localparam logic [5:0] ZIGZAG [0:63] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  // Raster address -> right-shift amount, (row+col)>>2.
  localparam logic [1:0] QSHIFT [0:63] = '{
    0, 0, 0, 0, 1, 1, 1, 1,
    0, 0, 0, 1, 1, 1, 1, 2,
    0, 0, 1, 1, 1, 1, 2, 2,
    0, 1, 1, 1, 1, 2, 2, 2,
    1, 1, 1, 1, 2, 2, 2, 2,
    1, 1, 1, 2, 2, 2, 2, 3,
    1, 1, 2, 2, 2, 2, 3, 3,
    1, 2, 2, 2, 2, 3, 3, 3
  };

endpackage

// File: rtl/dct_zigzag_quant_if.sv
// Coefficient write bus (from the DCT stage) and zigzag output stream.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid && ready; the sender holds its payload stable while valid && !ready.
interface dct_zigzag_quant_if
  import dct_pkg::*;
#(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/dct_shift_quant.sv
// Power-of-two divide with rounding half away from zero; s=0 passes x through.
module dct_shift_quant
  import dct_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_x,
  input  logic [1:0]        i_s,
  output logic [DATA_W-1:0] o_q
);
  logic          w_neg;
  logic [DATA_W:0] w_ext;
  logic [DATA_W:0] w_abs;
  logic [DATA_W:0] w_half;
  logic [DATA_W:0] w_mag;

  assign w_neg = i_x[DATA_W-1];
  assign w_ext = {w_neg, i_x};

  // One extra bit keeps |most-negative| representable.
  always_comb begin
    w_abs  = w_neg ? (~w_ext + 1'b1) : w_ext;
    w_half = '0;
    if (i_s != 2'd0) w_half = (DATA_W+1)'(1) << (i_s - 2'd1);
    w_mag  = (w_abs + w_half) >> i_s;
    if (i_s == 2'd0) o_q = i_x;
    else if (w_neg) o_q = ~w_mag[DATA_W-1:0] + 1'b1;
    else            o_q = w_mag[DATA_W-1:0];
  end
endmodule

// File: rtl/dct_zigzag_quant.sv
// Ping-pong coefficient buffer: raster-order writes in, quantized zigzag-order
// stream out, with a one-deep prefetch stage so the stream runs at 1/clk.
module dct_zigzag_quant
  import dct_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int QUANT_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dct_zigzag_quant_if.slave      bus,
  output rd_state_t              o_dbg_state
);
  logic [DATA_W-1:0] r_mem [0:2*BLOCK_SIZE-1];
  logic [1:0]        r_full;
  logic              r_wsel;
  logic              r_rsel;
  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [6:0]        r_fetch_cnt;
  logic              r_rd_vld;
  logic [5:0]        r_rd_k;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [5:0]        r_out_index;
  logic              r_out_last;

  logic              w_wr_fire;
  logic              w_out_fire;
  logic              w_blk_done;
  logic              w_load_out;
  logic              w_rd_free;
  logic              w_fetch_en;
  logic              w_fetch_bank;
  logic [5:0]        w_fetch_k;
  logic              w_fetch_restart;
  logic [1:0]        w_shift;
  logic [DATA_W-1:0] w_q_raw;
  logic [DATA_W-1:0] w_q;

  assign bus.in_ready  = !r_full[r_wsel];
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;
  assign bus.out_last  = r_out_last;
  assign o_dbg_state   = r_state;

  assign w_wr_fire  = bus.in_valid && bus.in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;
  assign w_blk_done = w_out_fire && r_out_last;
  assign w_load_out = r_rd_vld && (!r_out_valid || bus.out_ready);
  assign w_rd_free  = !r_rd_vld || w_load_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RD_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fetch control: a read is issued only when the prefetch slot will be free.
  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_en      = 1'b0;
    w_fetch_bank    = r_rsel;
    w_fetch_k       = r_fetch_cnt[5:0];
    w_fetch_restart = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (r_full[r_rsel]) begin
          w_fetch_en      = 1'b1;
          w_fetch_k       = 6'd0;
          w_fetch_restart = 1'b1;
          w_state_nxt     = RD_PRIME;
        end
      end
      RD_PRIME: begin
        if (w_rd_free && r_fetch_cnt < 7'(BLOCK_SIZE)) w_fetch_en = 1'b1;
        if (w_load_out) w_state_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        if (w_rd_free && r_fetch_cnt < 7'(BLOCK_SIZE)) w_fetch_en = 1'b1;
        if (w_blk_done) begin
          if (r_full[!r_rsel]) begin
            w_fetch_en      = 1'b1;
            w_fetch_bank    = !r_rsel;
            w_fetch_k       = 6'd0;
            w_fetch_restart = 1'b1;
            w_state_nxt     = RD_PRIME;
          end else begin
            w_state_nxt = RD_IDLE;
          end
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[{r_wsel, bus.in_addr}] <= bus.in_data;
    if (w_fetch_en) r_rd_data <= r_mem[{w_fetch_bank, ZIGZAG[w_fetch_k]}];
  end

  assign w_shift = QSHIFT[ZIGZAG[r_rd_k]];

  dct_shift_quant #(.DATA_W(DATA_W)) u_quant (
    .i_x (r_rd_data),
    .i_s (w_shift),
    .o_q (w_q_raw)
  );

  assign w_q = (QUANT_EN != 0) ? w_q_raw : r_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full      <= 2'b00;
      r_wsel      <= 1'b0;
      r_rsel      <= 1'b0;
      r_fetch_cnt <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_k      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else begin
      // Free before set: the two never target the same bank in one cycle.
      if (w_blk_done) begin
        r_full[r_rsel] <= 1'b0;
        r_rsel         <= !r_rsel;
      end
      if (w_wr_fire && bus.in_addr == 6'd63) begin
        r_full[r_wsel] <= 1'b1;
        r_wsel         <= !r_wsel;
      end
      if (w_fetch_en) begin
        r_fetch_cnt <= w_fetch_restart ? 7'd1 : r_fetch_cnt + 7'd1;
        r_rd_vld    <= 1'b1;
        r_rd_k      <= w_fetch_k;
      end else if (w_load_out) begin
        r_rd_vld    <= 1'b0;
      end
      if (w_load_out) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_q;
        r_out_index <= r_rd_k;
        r_out_last  <= (r_rd_k == 6'd63);
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/dct_zigzag_quant.md
Name: dct_zigzag_quant

Overview:
- Stage directly downstream of the 8x8 2-D DCT datapath/controller pair.
- Captures the 64 signed DCT coefficients of a block, written by raster address (0..63, row-major).
- Re-emits them in JPEG zigzag order, each coefficient quantized by a per-position power-of-two divide with symmetric rounding.
- Ping-pong buffered, so one block can load while the previous one drains to the entropy-coding side.

Parameters:
- DATA_W, 16, coefficient width (signed two's complement), input and output.
- QUANT_EN, 1, 1 applies the shift quantizer; 0 passes coefficients unchanged (reorder only).

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, coefficient write strobe from the DCT stage.
- in_addr, input, 6, raster address (row*8+col) of in_data.
- in_data, input, DATA_W, signed DCT coefficient.
- in_ready, output, 1, a write bank is free; a write happens only when in_valid && in_ready.
- out_valid, output, 1, out_data/out_index/out_last are valid.
- out_ready, input, 1, downstream accepts the current output.
- out_data, output, DATA_W, quantized coefficient.
- out_index, output, 6, zigzag index k (0..63) of out_data.
- out_last, output, 1, high with k=63.

Behaviour:
- Storage: two banks of 64 x DATA_W. Each bank has a full flag. There is a write pointer wsel and a read pointer rsel.
- in_ready = !full[wsel], combinational from registered flags.
- Writes may arrive in any address order. An accepted write at in_addr==63 sets full[wsel] and toggles wsel.
- Unwritten entries keep stale contents; no per-entry tracking.
- Read FSM states:
  - IDLE: on full[rsel], go to PRIME and issue a synchronous read of raster ZIGZAG[0].
  - PRIME: data returns one cycle later. Load the output register, set out_valid, go to STREAM.
  - STREAM: the output register advances when out_ready && out_valid; it is also loadable when !out_valid. Reads are prefetched so throughput is 1 coefficient/clk with out_ready held high. Holding out_ready low freezes all outputs and the read index (no drop, no duplicate).
  - On the out_last handshake: clear full[rsel], toggle rsel, go to IDLE. If the other bank is already full, go directly to PRIME (gap at most 1 idle cycle).
- Latency: addr-63 write accepted at edge N, so out_valid is high after edge N+2 when the reader is idle.
- Simultaneous events:
  - A bank freed by the out_last handshake in the same cycle as an in_valid attempt: in_ready rises the following cycle (registered flag).
  - A write to bank A and a read of bank B in the same cycle are independent.
- Quantization, per raster position p=(r,c): s = QSHIFT[p] = (r+c)>>2, range 0..3.
  - s=0: pass through.
  - Otherwise out = sign(x) * ((|x| + 2^(s-1)) >> s), rounding half away from zero.
  - Compute |x| at DATA_W+1 bits so -2^(DATA_W-1) does not overflow.
  - Result always fits DATA_W.
- Reset values: out_valid=0, out_data=0, out_index=0, out_last=0, both full flags=0, wsel=rsel=0, FSM=IDLE, so in_ready=1 during and after reset.
- Reset mid-block discards all partial and pending blocks; memory contents are not cleared.

Decomposition:
- Shared package dct_pkg holds:
  - ZIGZAG[0:63] table (zigzag index -> raster address; e.g. k0->0, k1->1, k2->8, k3->16, k4->9, k5->2, k63->63).
  - QSHIFT[0:63] table.
  - BLOCK_SIZE=64 and the read-FSM state enum.
- One sub-module: dct_shift_quant, the purely combinational rounding shifter (x, s -> q), unit-testable in isolation.

Test Plan:
- Write block with in_data = in_addr<<4, addr 0..63 consecutive, out_ready=1 -> out_valid 2 edges after the addr-63 write; 64 consecutive outputs; k0=0, k2=128 (raster 8, s=0), k5=32, k63=126 (raster 63: 1008, s=3 -> (1008+4)>>3), out_last only at k63.
- Negative rounding at raster 63 (s=3): in -5 -> -1, -3 -> 0, -4 -> -1, -32768 -> -4096. Same value at raster 0 -> unchanged.
- Back-pressure: toggle out_ready pseudo-randomly -> output sequence identical to the free-running case, and outputs held stable while out_ready=0.
- Ping-pong: out_ready=0, write two full blocks -> in_ready drops after the second addr-63 write. Third-block writes are refused. Releasing out_ready drains block 1 then block 2 with at most 1 idle cycle between them; in_ready rises one cycle after block-1 out_last.
- Out-of-order writes: addresses written in reverse 62..0, then 63 -> output identical to in-order case.
- Reset asserted at output k=20 -> all outputs 0 and in_ready=1 immediately. A fresh block after deassertion streams from k0 correctly.
